serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001: Parameter WIDTH, default 8, operand and result width in bits; legal range 2 to 32.
REQ-002: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003: rst_n  input  1  reset, asynchronous and active-low.
REQ-004: start  input  1  request to begin an addition; sampled on the rising edge.
REQ-005: A  input  WIDTH  first operand, captured when start is accepted.
REQ-006: B  input  WIDTH  second operand, captured when start is accepted.
REQ-007: Cin  input  1  carry-in, captured when start is accepted.
REQ-008: busy  output  1  high while an addition is in progress.
REQ-009: done  output  1  single-cycle pulse: result valid and freshly updated.
REQ-010: S  output  WIDTH  registered sum of the last completed addition.
REQ-011: Cout  output  1  registered carry-out of the last completed addition.

Function
REQ-012: The block SHALL add A + B + Cin one bit per clock, LSB first, using exactly one full_adder instance and a 1-bit carry register.
REQ-013: The block SHALL implement states IDLE, SHIFT and DONE, encoded in a registered state variable.
REQ-014: In IDLE or DONE with start=1 at an edge, the block SHALL capture A and B into operand shift registers, load the carry register with Cin, clear the bit counter, and enter SHIFT.
REQ-015: In SHIFT, each edge SHALL: feed bit 0 of both operand registers and the carry register to the full adder; shift both operand registers right by one; shift the sum bit into the MSB of an internal sum register; load the carry register from the full adder carry-out; increment the bit counter.
REQ-016: In SHIFT, when the counter equals WIDTH-1, the same edge SHALL enter DONE and load S from the completed internal sum register and Cout from the final carry-out.
REQ-017: From start acceptance at edge T0, done SHALL be high during the cycle after edge T0+WIDTH; latency is WIDTH cycles.
REQ-018: busy SHALL be high exactly in SHIFT; done SHALL be high exactly in DONE.
REQ-019: DONE SHALL last one cycle; the next edge enters IDLE when start=0, or enters SHIFT and captures new operands when start=1 (back-to-back operation).
REQ-020: start SHALL be ignored while in SHIFT; captured operands SHALL NOT be affected by changes on A, B or Cin after acceptance.
REQ-021: S and Cout SHALL hold their values from the previous completion until the next completion, including throughout SHIFT.
REQ-022: The result SHALL equal (A + B + Cin) modulo 2^WIDTH on S, with bit WIDTH of the exact sum on Cout.

Reset
REQ-023: While rst_n=0, the block SHALL force state IDLE, busy=0, done=0, S=0, Cout=0, and clear the counter, carry, operand and sum registers, independent of clk.
REQ-024: Reset asserted during SHIFT SHALL abort the operation; no done pulse SHALL follow, and S and Cout SHALL read 0.
REQ-025: On the first rising edge after rst_n deasserts, start=1 SHALL be accepted as in IDLE.

Verification (WIDTH=8)
REQ-026: A=0x0F, B=0x01, Cin=0, start 1 cycle -> busy for 8 cycles, done pulse 8 cycles after the start edge, S=0x10, Cout=0.
REQ-027: A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1; then A=0xFF, B=0xFF, Cin=1 -> S=0xFF, Cout=1; S holds 0x00 throughout the second operation until its done.
REQ-028: start=1 pulsed again at cycle 3 of SHIFT with A=0xAA, B=0x55 -> ignored; original result delivered on schedule, no extra done.
REQ-029: rst_n driven low at cycle 4 of SHIFT -> busy, done, S and Cout go to 0 immediately; no done after release.
REQ-030: start held high continuously with new operands presented each DONE cycle -> a done pulse every 9 cycles, each result correct.
REQ-031: Randomized A, B, Cin over at least 1000 operations -> every {Cout,S} equals A+B+Cin computed by the bench.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: adds A + B + Cin one bit per clock, LSB first,
// through a single full adder and a one-bit carry register.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s_c,
    output logic co_c
);

    assign s_c  = a ^ b ^ ci;
    assign co_c = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s_c;
    logic             fa_co_c;
    logic             accept_c;
    logic             last_c;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .ci   (carry),
        .s_c  (fa_s_c),
        .co_c (fa_co_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured outside SHIFT
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        last_c     = (cnt == CW'(WIDTH - 1));
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (last_c) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status flags registered from the next state so they track the state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == SHIFT);
            done <= (state_next == DONE);
        end
    end

    // Operand/sum shifters, carry and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept_c) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh <= {fa_s_c, sum_sh[WIDTH-1:1]};
            carry  <= fa_co_c;
            cnt    <= cnt + CW'(1);
        end
    end

    // Result registers only change on the final shift edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            Cout <= 1'b0;
        end else if (state == SHIFT && last_c) begin
            S    <= {fa_s_c, sum_sh[WIDTH-1:1]};
            Cout <= fa_co_c;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized scoreboard bench for serial_adder (WIDTH=8).

module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;

    logic [W:0]   exp_q[$];
    logic [W:0]   prev_res;
    logic [W:0]   mon_exp;
    int           checks;
    int           errors;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int unsigned sum;
        sum = int'(a) + int'(b) + int'(c);
        return sum[W:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got S=0x%0h Cout=%0b, required no done pulse", S, Cout);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", 32'({Cout, S}), 32'(mon_exp));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int pulse_at, input int abort_at);
        logic [W:0] res;
        bit         seen;
        int         done_n;
        res    = model(a, b, c);
        seen   = 1'b0;
        done_n = 0;
        @(negedge clk);
        start = 1'b1; A = a; B = b; Cin = c;
        exp_q.push_back(res);
        @(posedge clk);
        #1;
        start = 1'b0; A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
        for (int n = 1; n <= 30 && !seen; n++) begin
            @(negedge clk);
            if (abort_at != 0 && n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_s", 32'(S), 32'd0);
                check("abort_cout", 32'(Cout), 32'd0);
                void'(exp_q.pop_back());
                prev_res = '0;
                return;
            end
            if (done) begin
                seen   = 1'b1;
                done_n = n;
            end else begin
                check("busy_in_shift", 32'(busy), 32'd1);
                check("s_hold", 32'(S), 32'(prev_res[W-1:0]));
                check("cout_hold", 32'(Cout), 32'(prev_res[W]));
            end
            if (pulse_at != 0 && n == pulse_at) begin
                start = 1'b1; A = 8'hAA; B = 8'h55;
            end else begin
                start = 1'b0;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in 30 cycles, required done after %0d", W + 1);
            return;
        end
        check("latency", 32'(done_n), 32'(W + 1));
        prev_res = res;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);
    endtask

    // Start held high; new operands appear during each DONE cycle
    task automatic b2b(input int cnt);
        logic [W:0] res;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic c;
        int gap;
        bit seen;
        a = W'($urandom); b = W'($urandom); c = 1'($urandom);
        res = model(a, b, c);
        @(negedge clk);
        start = 1'b1; A = a; B = b; Cin = c;
        exp_q.push_back(res);
        for (int k = 0; k < cnt; k++) begin
            seen = 1'b0;
            gap  = 0;
            while (!seen && gap < 30) begin
                @(negedge clk);
                gap++;
                if (done) seen = 1'b1;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL b2b_timeout: got no done in 30 cycles, required period %0d", W + 1);
                start = 1'b0;
                return;
            end
            check("b2b_period", 32'(gap), 32'(W + 1));
            if (k < cnt - 1) begin
                a = W'($urandom); b = W'($urandom); c = 1'($urandom);
                res = model(a, b, c);
                A = a; B = b; Cin = c;
                exp_q.push_back(res);
            end else begin
                start = 1'b0;
            end
        end
        prev_res = res;
        @(negedge clk);
        check("b2b_end_done", 32'(done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        prev_res = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(S), 32'd0);
        check("rst_cout", 32'(Cout), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // First edge after reset release accepts start
        run_op(8'h0F, 8'h01, 1'b0, 0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 0);

        // Start during SHIFT is ignored
        run_op(8'h12, 8'h34, 1'b0, 3, 0);
        repeat (12) begin
            @(negedge clk);
            check("no_extra_done", 32'(done), 32'd0);
        end

        // Reset mid-operation aborts it
        run_op(8'h5A, 8'hC3, 1'b1, 0, 4);
        repeat (2) begin
            @(negedge clk);
            check("in_rst_s", 32'(S), 32'd0);
            check("in_rst_busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            check("no_done_after_abort", 32'(done), 32'd0);
        end

        b2b(6);

        for (int i = 0; i < 1000; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0, 0);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
